// File: rtl/relu_ctrl.sv
// relu_ctrl: sequencer for the ReLU stage of the systolic-array output path.
// After a start pulse it reads num_rows rows of ARRAYWIDTH signed lanes from
// the output buffer, applies per-lane ReLU (or bypass) and writes each row to
// the destination buffer. At most two rows are in flight. They are held in an
// output register plus one skid entry, so write backpressure loses nothing.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   start                    begin a job (sampled only in IDLE)
//   relu_en                  1 = ReLU, 0 = bypass (latched at start)
//   src_base, dst_base       first source / destination row address (latched)
//   num_rows                 rows to process (latched)
//   busy, done               job active / one-cycle completion pulse
//   rd_en, rd_addr, rd_data  source read; data valid one cycle after rd_en
//   wr_en, wr_addr, wr_data  destination write, held while wr_ready is low
//   wr_ready                 destination accepts on wr_en && wr_ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing reads, limited to 2 rows in flight
// DRAIN | all reads issued, waiting for in-flight rows to be written
// DONE  | one-cycle done pulse, then back to IDLE

`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif

module relu_ctrl #(
  parameter int ARRAYWIDTH = `ARRAYWIDTH,
  parameter int DATASIZE   = `OUTPUT_BUF_DATASIZE,
  parameter int ADDRW      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           relu_en,
  input  logic [ADDRW-1:0]               src_base,
  input  logic [ADDRW-1:0]               dst_base,
  input  logic [ADDRW-1:0]               num_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [ADDRW-1:0]               rd_addr,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] rd_data,
  output logic                           wr_en,
  output logic [ADDRW-1:0]               wr_addr,
  output logic [ARRAYWIDTH*DATASIZE-1:0] wr_data,
  input  logic                           wr_ready
);

  localparam int RW = ARRAYWIDTH * DATASIZE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             relu_en_q;
  logic [ADDRW-1:0] src_base_q, dst_base_q, num_rows_q;
  logic [ADDRW-1:0] issued_q, issued_d;
  logic [ADDRW-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]       occ_q, occ_d;
  logic             rd_vld_q;
  logic             skid_vld_q, skid_vld_d;
  logic [RW-1:0]    skid_data_q, skid_data_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [RW-1:0]    wr_data_q, wr_data_d;
  logic [RW-1:0]    relu_row;
  logic             accept, out_free, start_job;

  assign accept   = wr_en_q & wr_ready;
  assign out_free = ~wr_en_q | accept;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    rd_en     = 1'b0;
    start_job = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_job = 1'b1;
          issued_d  = '0;
          state_d   = (num_rows == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // A write accepted this cycle frees a slot, so reads resume at once.
        if (occ_q < 2'd2 || accept) begin
          rd_en    = 1'b1;
          issued_d = issued_q + 1'b1;
          if (issued_q == num_rows_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the last row is accepted so done lands on the next cycle.
        if (occ_q == {1'b0, accept}) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q + {1'b0, rd_en} - {1'b0, accept};
    if (start_job) occ_d = '0;
  end

  always_comb begin
    relu_row = rd_data;
    for (int i = 0; i < ARRAYWIDTH; i++) begin
      if (relu_en_q && rd_data[i*DATASIZE + DATASIZE-1]) relu_row[i*DATASIZE +: DATASIZE] = '0;
    end
  end

  // The skid entry always holds the older row, so it is drained first.
  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_cnt_d    = wr_cnt_q;
    if (out_free) begin
      wr_en_d = 1'b0;
      if (skid_vld_q) begin
        wr_en_d    = 1'b1;
        wr_data_d  = skid_data_q;
        wr_addr_d  = dst_base_q + wr_cnt_q;
        wr_cnt_d   = wr_cnt_q + 1'b1;
        skid_vld_d = rd_vld_q;
        if (rd_vld_q) skid_data_d = relu_row;
      end else if (rd_vld_q) begin
        wr_en_d   = 1'b1;
        wr_data_d = relu_row;
        wr_addr_d = dst_base_q + wr_cnt_q;
        wr_cnt_d  = wr_cnt_q + 1'b1;
      end
    end else if (rd_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = relu_row;
    end
    if (start_job) begin
      wr_cnt_d   = '0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      relu_en_q   <= 1'b0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      num_rows_q  <= '0;
      issued_q    <= '0;
      wr_cnt_q    <= '0;
      occ_q       <= '0;
      rd_vld_q    <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      wr_cnt_q    <= wr_cnt_d;
      occ_q       <= occ_d;
      rd_vld_q    <= rd_en;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (start_job) begin
        relu_en_q  <= relu_en;
        src_base_q <= src_base;
        dst_base_q <= dst_base;
        num_rows_q <= num_rows;
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_addr = src_base_q + issued_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_relu_ctrl.sv
module tb_relu_ctrl;

  localparam int AW    = 4;
  localparam int DS    = 16;
  localparam int ADDRW = 8;
  localparam int RW    = AW * DS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             relu_en = 1'b0;
  logic [ADDRW-1:0] src_base = '0;
  logic [ADDRW-1:0] dst_base = '0;
  logic [ADDRW-1:0] num_rows = '0;
  logic             busy, done, rd_en, wr_en;
  logic [ADDRW-1:0] rd_addr, wr_addr;
  logic [RW-1:0]    rd_data = '0;
  logic [RW-1:0]    wr_data;
  logic             wr_ready = 1'b1;

  relu_ctrl #(.ARRAYWIDTH(AW), .DATASIZE(DS), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .src_base(src_base), .dst_base(dst_base), .num_rows(num_rows),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] mem [256];

  // Source buffer: data valid one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] relu_model(input logic [RW-1:0] x, input bit en);
    logic [RW-1:0] y;
    logic [DS-1:0] lane;
    y = '0;
    for (int j = 0; j < AW; j++) begin
      lane = x[j*DS +: DS];
      y[j*DS +: DS] = (en && lane[DS-1]) ? '0 : lane;
    end
    return y;
  endfunction

  typedef struct {
    bit            relu;
    logic [7:0]    src, dst, n;
    int            stall_lo, stall_hi;
    int            inj;
    int            exp_done;
    bit            chk0;
    logic [RW-1:0] exp0;
  } vec_t;

  vec_t vecs[7];

  task automatic run_job(input int id, input vec_t v);
    logic [7:0]    rda[$];
    logic [7:0]    wra[$];
    logic [RW-1:0] wrd[$];
    int            first_rd, last_rd, first_wr, last_wr, done_cnt, done_at, occ, max_occ;
    bit            prev_stall;
    logic [7:0]    prev_addr;
    logic [RW-1:0] prev_data;
    first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
    done_cnt = 0; done_at = -1; occ = 0; max_occ = 0;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    relu_en = v.relu; src_base = v.src; dst_base = v.dst; num_rows = v.n;
    wr_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      wr_ready = !(c >= v.stall_lo && c <= v.stall_hi);
      if (v.inj != 0 && c == v.inj) begin
        start = 1'b1; relu_en = !v.relu; src_base = 8'h90; dst_base = 8'hA0; num_rows = 8'd2;
      end else if (v.inj != 0 && c == v.inj + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("v%0d busy c%0d", id, c), busy, c <= v.exp_done);
      if (prev_stall) begin
        chk($sformatf("v%0d hold wr_en c%0d", id, c), wr_en, 1);
        chk($sformatf("v%0d hold wr_addr c%0d", id, c), wr_addr, prev_addr);
        chk($sformatf("v%0d hold wr_data c%0d", id, c), wr_data, prev_data);
      end
      if (rd_en) begin
        rda.push_back(rd_addr);
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        occ++;
      end
      if (wr_en && wr_ready) begin
        wra.push_back(wr_addr);
        wrd.push_back(wr_data);
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        occ--;
      end
      if (occ > max_occ) max_occ = occ;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (c <= v.exp_done) begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("v%0d read count", id), rda.size(), v.n);
    for (int i = 0; i < rda.size() && i < int'(v.n); i++)
      chk($sformatf("v%0d rd_addr[%0d]", id, i), rda[i], 8'(v.src + i));
    chk($sformatf("v%0d write count", id), wra.size(), v.n);
    for (int i = 0; i < wra.size() && i < int'(v.n); i++) begin
      chk($sformatf("v%0d wr_addr[%0d]", id, i), wra[i], 8'(v.dst + i));
      chk($sformatf("v%0d wr_data[%0d]", id, i), wrd[i], relu_model(mem[8'(v.src + i)], v.relu));
    end
    chk($sformatf("v%0d done count", id), done_cnt, 1);
    chk($sformatf("v%0d done cycle", id), done_at, v.exp_done);
    chk($sformatf("v%0d max occupancy ok", id), max_occ <= 2, 1);
    if (v.stall_lo == 0 && v.n != 0) begin
      chk($sformatf("v%0d first rd cycle", id), first_rd, 1);
      chk($sformatf("v%0d last rd cycle", id), last_rd, v.n);
      chk($sformatf("v%0d first wr cycle", id), first_wr, 3);
      chk($sformatf("v%0d last wr cycle", id), last_wr, v.n + 2);
    end
    if (v.chk0 && wrd.size() > 0)
      chk($sformatf("v%0d hand row0", id), wrd[0], v.exp0);
  endtask

  initial begin
    logic [7:0] ab;
    int seen;
    for (int a = 0; a < 256; a++) begin
      ab = 8'(a);
      for (int j = 0; j < AW; j++) mem[a][j*DS +: DS] = {8'(ab ^ 8'(j*64)), 8'(j*55 + a)};
    end
    mem[8'h10] = 64'h7FFF_8000_FFFF_0005;
    mem[8'h11] = 64'h7FFF_8000_FFFF_0005;
    mem[8'h12] = 64'h7FFF_8000_FFFF_0005;

    //          relu  src    dst    n     lo hi inj done chk0  exp0
    vecs[0] = '{1'b1, 8'h10, 8'h40, 8'd3, 0, 0, 0,  6,   1'b1, 64'h7FFF_0000_0000_0005};
    vecs[1] = '{1'b0, 8'h10, 8'h40, 8'd3, 0, 0, 0,  6,   1'b1, 64'h7FFF_8000_FFFF_0005};
    vecs[2] = '{1'b1, 8'h20, 8'h60, 8'd5, 3, 6, 0,  12,  1'b0, 64'h0};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 8'd0, 0, 0, 0,  1,   1'b0, 64'h0};
    vecs[4] = '{1'b1, 8'hFE, 8'hFD, 8'd3, 0, 0, 0,  6,   1'b0, 64'h0};
    vecs[5] = '{1'b0, 8'h80, 8'hFF, 8'd1, 0, 0, 0,  4,   1'b0, 64'h0};
    vecs[6] = '{1'b1, 8'h30, 8'h50, 8'd4, 0, 0, 2,  7,   1'b0, 64'h0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_job(k, vecs[k]);

    // Asynchronous reset in cycle 2 of a 4-row job.
    relu_en = 1'b1; src_base = 8'h10; dst_base = 8'h40; num_rows = 8'd4;
    wr_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst rd_en", rd_en, 0);
    chk("midrst rd_addr", rd_addr, 0);
    chk("midrst wr_en", wr_en, 0);
    chk("midrst wr_addr", wr_addr, 0);
    chk("midrst wr_data", wr_data, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst no done/busy", seen, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job(7, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/relu_ctrl.md
# relu_ctrl

Sequencer for the ReLU stage of the systolic-array output path. After a start pulse it streams `num_rows` rows of `ARRAYWIDTH` lanes from the output buffer. Each row goes through a per-lane ReLU (or bypass), and the result is written to the activation/destination buffer. It issues buffer reads, tracks in-flight rows, absorbs write backpressure without loss, and signals completion.

## Interface
- `ARRAYWIDTH`, default `` `ARRAYWIDTH `` (config.v), lanes per row
- `DATASIZE`, default `` `OUTPUT_BUF_DATASIZE `` (config.v), bits per lane, signed two's complement
- `ADDRW`, default 8, buffer address width
- `clk` in 1: the single clock, rising edge
- `rst` in 1: reset, asynchronous and active-high
- `start` in 1: begin a job; sampled only in IDLE
- `relu_en` in 1: 1 = apply ReLU, 0 = pass data through; latched at start
- `src_base` in ADDRW: first source row address; latched at start
- `dst_base` in ADDRW: first destination row address; latched at start
- `num_rows` in ADDRW: rows to process; latched at start
- `busy` out 1: high in RUN, DRAIN and DONE
- `done` out 1: one-cycle completion pulse
- `rd_en` out 1: source buffer read strobe
- `rd_addr` out ADDRW: source row address
- `rd_data` in ARRAYWIDTH*DATASIZE: row data, valid exactly 1 cycle after `rd_en`
- `wr_en` out 1: destination write valid
- `wr_addr` out ADDRW: destination row address
- `wr_data` out ARRAYWIDTH*DATASIZE: processed row
- `wr_ready` in 1: destination accepts the row when `wr_en && wr_ready`

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - On `start`, latch the configuration and clear the issued count and the occupancy `occ`.
  - If `num_rows == 0`, go to DONE; otherwise go to RUN.
- **Start while busy:** `start` is ignored in every state except IDLE.
- **RUN:**
  - Issue `rd_en` with `rd_addr = src_base + issued`, where `issued` counts reads already issued.
  - Issue only while `occ - (wr_en && wr_ready) < 2`.
  - After the read with `issued == num_rows-1`, go to DRAIN.
- **DRAIN:** `rd_en` stays low; go to DONE once `occ == 0`.
- **DONE:** `done = 1` for exactly one cycle, then go to IDLE.
- **Occupancy `occ`:** rows read but not yet accepted by the destination, range 0..2.
  - +1 per `rd_en`.
  - −1 per `wr_en && wr_ready`.
  - Both in the same cycle leaves it unchanged.
- **Storage:** one output register plus one skid entry.
  - Returning `rd_data` is processed and loaded into the output register if it is empty or draining this cycle; otherwise it goes to the skid entry.
  - The skid entry moves into the output register when the register drains.
  - Rows leave strictly in order and no row is lost or duplicated.
- **ReLU, per lane:** if `relu_en` and lane MSB = 1, output 0; else output the lane unchanged. No width change and no saturation.
- **Write address:** `wr_addr = dst_base + k` for the k-th row written, k from 0.
- **Address wrap:** both address sums wrap modulo 2^ADDRW.
- **Write hold:** while `wr_en && !wr_ready`, `wr_en`, `wr_addr` and `wr_data` hold stable.
- **Reset:**
  - Asynchronous, any time. State goes to IDLE and all counters, `occ` and the skid entry clear.
  - All outputs go to 0: `busy`, `done`, `rd_en`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`.
  - Reset mid-job abandons in-flight rows; no `done` is emitted.

## Timing
- Edge E0 samples `start`. `busy` is high from cycle 1.
- With `wr_ready` held high and N ≥ 1:
  - `rd_en` is high in cycles 1..N (one row per cycle).
  - `rd_data` arrives in cycles 2..N+1.
  - `wr_en` is high in cycles 3..N+2 (registered output; read-to-write latency 2).
  - `done` is high in cycle N+3; `busy` falls in cycle N+4.
- `num_rows = 0`: `done` is high in cycle 1 with no reads or writes.
- **Backpressure:**
  - At most 2 rows are in flight.
  - Reads resume in the same cycle a write is accepted.
  - Full throughput returns on the first cycle `wr_ready` is high again.
- **Next job:** a new `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- **Basic stream.** ARRAYWIDTH=4, DATASIZE=16, `relu_en=1`, src_base=0x10, dst_base=0x40, num_rows=3, rows {0x0005,0xFFFF,0x8000,0x7FFF}×3, `wr_ready` high.
  - Writes go to 0x40..0x42, each {0x0005,0x0000,0x0000,0x7FFF}.
  - `done` in cycle 6.
- **Bypass.** Same stimulus with `relu_en=0` → writes equal the source rows bit-exact.
- **Backpressure.** num_rows=5, `wr_ready` low for cycles 3..6.
  - `wr_en`, `wr_addr` and `wr_data` held stable during the stall.
  - `occ` never exceeds 2; no rows lost or duplicated.
  - All 5 rows written in order.
- **Zero rows and wrap.**
  - num_rows=0 → `done` in cycle 1 and no `rd_en`/`wr_en`.
  - src_base=0xFE, num_rows=3 → reads 0xFE, 0xFF, 0x00.
- **Ignored start.** Pulse `start` during RUN with different config → ignored; the original job completes with the original addresses.
- **Mid-job reset.** Assert `rst` in cycle 2 of a 4-row job → all outputs 0 immediately and no `done`; a following job runs normally.
